regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side companion of the 8x16 register file.
- Accepts result write requests from two producers, the ALU and the memory/load path, through valid/ready handshakes, and buffers them in a small in-order queue.
- Drains the queue at one write per cycle onto the register file's write port (write enable, destination, data), and maintains the LC-3 style N/Z/P condition codes.
- Provides a combinational pending-write hazard lookup so the decode stage can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, number of queued write entries; power of two, minimum 2.
- DATA_W, 16, register data width; must match the register file.
- ADDR_W, 3, register index width (8 registers).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result request.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready.
- alu_dr  in  ADDR_W  ALU destination register.
- alu_value  in  DATA_W  ALU result.
- alu_set_cc  in  1  this write updates the condition codes.
- mem_valid  in  1  load-result request.
- mem_ready  out  1  load request accepted this cycle when mem_valid && mem_ready.
- mem_dr  in  ADDR_W  load destination register.
- mem_value  in  DATA_W  loaded data.
- mem_set_cc  in  1  this load updates the condition codes.
- wb_hold  in  1  suppresses draining for this cycle.
- reg_we  out  1  register file write enable (registered).
- reg_dr  out  ADDR_W  register file write address (registered).
- reg_wdata  out  DATA_W  register file write data (registered).
- cc_n, cc_z, cc_p  out  1 each  condition codes (registered).
- qry_sr1, qry_sr2  in  ADDR_W  source registers to check for hazards.
- hz_sr1, hz_sr2  out  1  pending write exists to the queried register.
- count  out  clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset values:
  - reg_we=0, reg_dr=0, reg_wdata=0.
  - cc_n=0, cc_z=1, cc_p=0.
  - count=0; the queue is empty.
- Reset mid-operation discards all queued entries and any in-flight output write. No write is issued in the cycle after reset.
- Queue entry fields: {dr, value, set_cc}. Entries drain strictly in FIFO order.
- Ready rules (combinational, from registered count only):
  - alu_ready = (count < DEPTH).
  - mem_ready = (count + (alu_valid ? 1 : 0) < DEPTH).
- Simultaneous push: when both producers push in the same cycle, the ALU entry is enqueued ahead of the MEM entry.
- With one free slot and both producers valid, only the ALU push is accepted and mem_ready=0.
- Drain: each edge where count>0 and wb_hold=0, the head is popped and reg_we<=1, reg_dr<=head.dr, reg_wdata<=head.value. Otherwise reg_we<=0, and reg_dr/reg_wdata hold their previous values.
- Latency:
  - A push accepted at edge k into an empty queue is popped at edge k+1.
  - reg_we is high during the cycle after edge k+1.
  - The register file commits the write at edge k+2.
- No bypass from the inputs directly to the outputs.
- Push and pop in the same edge are legal:
  - count_next = count + pushes - pop.
  - When full, a pop frees its slot only for the next cycle, because ready is computed from the registered count.
- Condition codes: updated at the same edge as the pop, only when head.set_cc=1.
  - N = value[15].
  - Z = (value == 0).
  - P = !N && !Z.
  - Exactly one of N/Z/P is high at all times.
- Hazard lookup (combinational): hz_srX=1 if any valid queue entry has dr==qry_srX, or if reg_we=1 && reg_dr==qry_srX. The in-flight output counts because the register file has not yet written it.
- No producer-side error state: a request that is not accepted must be held by the producer. Data inputs are ignored when valid=0.
- Same-register writes are never merged; both are issued in order, and the later one wins in the register file.

Decomposition:
- Shared package holds:
  - constants REG_DATA_W=16, REG_ADDR_W=3, NUM_REGS=8;
  - typedef wb_entry_t {dr, value, set_cc};
  - reset constant CC_RESET=3'b010.
- One sub-module, wb_fifo: synchronous circular buffer with two ordered push ports, one pop port, occupancy output, and an entry-array view for the hazard compare.
- The top level holds the ready logic, output registers, CC logic and hazard comparators.

Test Plan:
- Single ALU push {dr=3, value=16'h8001, set_cc=1} at edge 0 -> reg_we=1, reg_dr=3, reg_wdata=16'h8001 after edge 1; cc_n=1, cc_z=0, cc_p=0; count returns to 0.
- Simultaneous ALU {dr=1, 16'h0005} and MEM {dr=1, 16'h0000, set_cc=1} into an empty queue -> writes issued dr1=0005 then dr1=0000 on consecutive cycles; final cc_z=1.
- Hold wb_hold=1 and push 4 entries -> count=4, alu_ready=0, mem_ready=0. Then push both producers with count=3 -> only the ALU is accepted. Release the hold -> 4 writes issued in order, one per cycle.
- After a push to dr=6 with wb_hold=1 -> hz_sr1=1 for qry_sr1=6 and hz_sr2=0 for qry_sr2=5. The hazard stays high through the reg_we cycle and clears the cycle after.
- Assert rst with 3 entries queued and reg_we=1 -> next cycle reg_we=0, count=0, cc=010, and no further writes occur.
- Push {dr=2, 16'h7FFF, set_cc=0} -> register write issued and cc unchanged from the prior value.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file writeback path.
// Entry layout, condition-code reset value and the N/Z/P derivation helper.
package regfile_writeback_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    // {n, z, p}
    localparam logic [2:0] CC_RESET = 3'b010;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dr;
        logic [REG_DATA_W-1:0] value;
        logic                  set_cc;
    } wb_entry_t;

    function automatic logic [2:0] cc_of(input logic [REG_DATA_W-1:0] v);
        logic n;
        logic z;
        n = v[REG_DATA_W-1];
        z = (v == '0);
        return {n, z, !n && !z};
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer requests, register-file write port, condition codes and hazard query
// of the writeback block; slave is the block side, master the surrounding pipeline.
interface regfile_writeback_if
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dr;
    logic [DATA_W-1:0] alu_value;
    logic              alu_set_cc;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dr;
    logic [DATA_W-1:0] mem_value;
    logic              mem_set_cc;

    logic              wb_hold;

    logic              reg_we;
    logic [ADDR_W-1:0] reg_dr;
    logic [DATA_W-1:0] reg_wdata;
    logic              cc_n;
    logic              cc_z;
    logic              cc_p;

    logic [ADDR_W-1:0] qry_sr1;
    logic [ADDR_W-1:0] qry_sr2;
    logic              hz_sr1;
    logic              hz_sr2;

    logic [CNT_W-1:0]  count;

    modport slave (
        input  alu_valid, alu_dr, alu_value, alu_set_cc,
        input  mem_valid, mem_dr, mem_value, mem_set_cc,
        input  wb_hold, qry_sr1, qry_sr2,
        output alu_ready, mem_ready,
        output reg_we, reg_dr, reg_wdata, cc_n, cc_z, cc_p,
        output hz_sr1, hz_sr2, count
    );

    modport master (
        output alu_valid, alu_dr, alu_value, alu_set_cc,
        output mem_valid, mem_dr, mem_value, mem_set_cc,
        output wb_hold, qry_sr1, qry_sr2,
        input  alu_ready, mem_ready,
        input  reg_we, reg_dr, reg_wdata, cc_n, cc_z, cc_p,
        input  hz_sr1, hz_sr2, count
    );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order writeback queue: two ordered push ports (port 0 lands first), one pop port.
// Latency: a push is visible at the head one edge later; no internal bypass.
// Backpressure: none internally; callers must never push beyond free slots.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push0,
    input  wb_entry_t                           push0_dat,
    input  logic                                push1,
    input  wb_entry_t                           push1_dat,
    input  logic                                pop,
    output wb_entry_t                           head,
    output logic [$clog2(DEPTH):0]              count,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_dr,
    output logic [DEPTH-1:0]                    entry_vld
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      wr_ptr1;
    logic [CNT_W-1:0]      cnt;
    logic [PTR_W-1:0]      off;

    // Port 1 goes into the slot after port 0 only when port 0 is also pushing.
    assign wr_ptr1 = wr_ptr + PTR_W'(push0);

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= push0_dat;
        if (push1) mem[wr_ptr1] <= push1_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            cnt    <= cnt + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PTR_W'(i) - rd_ptr;
            entry_vld[i] = ({1'b0, off} < cnt);
            entry_dr[i]  = mem[i].dr;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results into one in-order queue feeding the register-file write port.
// Latency: push at edge k -> popped at k+1 -> reg_we high after k+1, committed at k+2.
// Backpressure: ready from registered occupancy only; ALU has priority for the last free slot.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  wb
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0]                 fifo_count;
    logic                             alu_push;
    logic                             mem_push;
    logic                             pop;
    wb_entry_t                        alu_ent;
    wb_entry_t                        mem_ent;
    wb_entry_t                        head;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dr;
    logic [DEPTH-1:0]                 ent_vld;

    logic              reg_we_q;
    logic [ADDR_W-1:0] reg_dr_q;
    logic [DATA_W-1:0] reg_wdata_q;
    logic [2:0]        cc_q;
    logic              hz1;
    logic              hz2;

    assign wb.alu_ready = (fifo_count < DEPTH_C);
    assign wb.mem_ready = (({1'b0, fifo_count} + {{CNT_W{1'b0}}, wb.alu_valid}) < DEPTH_X);

    assign alu_push = wb.alu_valid && wb.alu_ready;
    assign mem_push = wb.mem_valid && wb.mem_ready;
    assign pop      = (fifo_count != '0) && !wb.wb_hold;

    assign alu_ent = '{dr: wb.alu_dr, value: wb.alu_value, set_cc: wb.alu_set_cc};
    assign mem_ent = '{dr: wb.mem_dr, value: wb.mem_value, set_cc: wb.mem_set_cc};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0     (alu_push),
        .push0_dat (alu_ent),
        .push1     (mem_push),
        .push1_dat (mem_ent),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .entry_dr  (ent_dr),
        .entry_vld (ent_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we_q    <= 1'b0;
            reg_dr_q    <= '0;
            reg_wdata_q <= '0;
            cc_q        <= CC_RESET;
        end else begin
            reg_we_q <= pop;
            if (pop) begin
                reg_dr_q    <= head.dr;
                reg_wdata_q <= head.value;
                if (head.set_cc) cc_q <= cc_of(head.value);
            end
        end
    end

    // The write on the output port is still pending until the register file commits it.
    always_comb begin
        hz1 = reg_we_q && (reg_dr_q == wb.qry_sr1);
        hz2 = reg_we_q && (reg_dr_q == wb.qry_sr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_dr[i] == wb.qry_sr1)) hz1 = 1'b1;
            if (ent_vld[i] && (ent_dr[i] == wb.qry_sr2)) hz2 = 1'b1;
        end
    end

    assign wb.reg_we    = reg_we_q;
    assign wb.reg_dr    = reg_dr_q;
    assign wb.reg_wdata = reg_wdata_q;
    assign wb.cc_n      = cc_q[2];
    assign wb.cc_z      = cc_q[1];
    assign wb.cc_p      = cc_q[0];
    assign wb.hz_sr1    = hz1;
    assign wb.hz_sr2    = hz2;
    assign wb.count     = fifo_count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then constrained-random traffic
// compared every cycle against a queue-based model of the writeback rules.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_writeback_if #(.DEPTH(DEPTH)) wb();

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t   mq[$];
    logic        m_we;
    logic [2:0]  m_dr;
    logic [15:0] m_wd;
    logic [2:0]  m_cc;
    bit          alu_acc;
    bit          mem_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hz_model(input logic [2:0] q);
        foreach (mq[i]) if (mq[i].dr == q) return 1'b1;
        return m_we && (m_dr == q);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0;
        m_dr = '0;
        m_wd = '0;
        m_cc = 3'b010;
    endtask

    task automatic idle();
        wb.alu_valid = 1'b0; wb.alu_dr = '0; wb.alu_value = '0; wb.alu_set_cc = 1'b0;
        wb.mem_valid = 1'b0; wb.mem_dr = '0; wb.mem_value = '0; wb.mem_set_cc = 1'b0;
    endtask

    task automatic set_alu(input logic [2:0] dr, input logic [15:0] v, input logic cc);
        wb.alu_valid = 1'b1; wb.alu_dr = dr; wb.alu_value = v; wb.alu_set_cc = cc;
    endtask

    task automatic set_mem(input logic [2:0] dr, input logic [15:0] v, input logic cc);
        wb.mem_valid = 1'b1; wb.mem_dr = dr; wb.mem_value = v; wb.mem_set_cc = cc;
    endtask

    // One clock: check combinational outputs before the edge, advance the model, check registers after.
    task automatic step();
        wb_entry_t ea;
        wb_entry_t em;
        wb_entry_t e;
        bit ar;
        bit mr;
        #1;
        ar = (mq.size() < DEPTH);
        mr = ((mq.size() + (wb.alu_valid ? 1 : 0)) < DEPTH);
        chk("alu_ready", wb.alu_ready, ar);
        chk("mem_ready", wb.mem_ready, mr);
        chk("hz_sr1", wb.hz_sr1, hz_model(wb.qry_sr1));
        chk("hz_sr2", wb.hz_sr2, hz_model(wb.qry_sr2));
        alu_acc = wb.alu_valid && ar;
        mem_acc = wb.mem_valid && mr;
        ea.dr = wb.alu_dr; ea.value = wb.alu_value; ea.set_cc = wb.alu_set_cc;
        em.dr = wb.mem_dr; em.value = wb.mem_value; em.set_cc = wb.mem_set_cc;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (mq.size() != 0 && !wb.wb_hold) begin
                e    = mq.pop_front();
                m_we = 1'b1;
                m_dr = e.dr;
                m_wd = e.value;
                if (e.set_cc) m_cc = {e.value[15], e.value == 16'h0, !e.value[15] && e.value != 16'h0};
            end else begin
                m_we = 1'b0;
            end
            if (alu_acc) mq.push_back(ea);
            if (mem_acc) mq.push_back(em);
        end
        #1;
        chk("reg_we", wb.reg_we, m_we);
        chk("reg_dr", wb.reg_dr, m_dr);
        chk("reg_wdata", wb.reg_wdata, m_wd);
        chk("cc", {wb.cc_n, wb.cc_z, wb.cc_p}, m_cc);
        chk("cc_onehot", $countones({wb.cc_n, wb.cc_z, wb.cc_p}), 1);
        chk("count", wb.count, mq.size());
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wb.wb_hold = 1'b0;
        wb.qry_sr1 = '0;
        wb.qry_sr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_we", wb.reg_we, 0);
        chk("rst_dr", wb.reg_dr, 0);
        chk("rst_wdata", wb.reg_wdata, 0);
        chk("rst_cc", {wb.cc_n, wb.cc_z, wb.cc_p}, 3'b010);
        chk("rst_count", wb.count, 0);
        rst = 1'b0;

        // Single ALU push with negative value
        set_alu(3'd3, 16'h8001, 1'b1);
        step();
        idle();
        step();
        chk("t1_we", wb.reg_we, 1);
        chk("t1_dr", wb.reg_dr, 3);
        chk("t1_wdata", wb.reg_wdata, 16'h8001);
        chk("t1_cc", {wb.cc_n, wb.cc_z, wb.cc_p}, 3'b100);
        chk("t1_count", wb.count, 0);
        step();

        // Simultaneous push: ALU first, then MEM
        set_alu(3'd1, 16'h0005, 1'b0);
        set_mem(3'd1, 16'h0000, 1'b1);
        step();
        idle();
        step();
        chk("t2_first", {wb.reg_we, wb.reg_dr, wb.reg_wdata}, {1'b1, 3'd1, 16'h0005});
        step();
        chk("t2_second", {wb.reg_we, wb.reg_dr, wb.reg_wdata}, {1'b1, 3'd1, 16'h0000});
        chk("t2_cc", {wb.cc_n, wb.cc_z, wb.cc_p}, 3'b010);
        step();

        // Fill under hold; last free slot goes to the ALU
        wb.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_alu(3'(i + 4), 16'(16'h0100 + i), 1'b1);
            step();
        end
        set_alu(3'd7, 16'h1234, 1'b1);
        set_mem(3'd2, 16'hFFFF, 1'b1);
        #1;
        chk("t3_alu_rdy3", wb.alu_ready, 1);
        chk("t3_mem_rdy3", wb.mem_ready, 0);
        step();
        wb.alu_valid = 1'b0;
        #1;
        chk("t3_count_full", wb.count, 4);
        chk("t3_alu_rdy_full", wb.alu_ready, 0);
        chk("t3_mem_rdy_full", wb.mem_ready, 0);
        wb.wb_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mem_acc) wb.mem_valid = 1'b0;
        end

        // Hazard on a queued entry and on the in-flight write
        wb.wb_hold = 1'b1;
        wb.qry_sr1 = 3'd6;
        wb.qry_sr2 = 3'd5;
        set_alu(3'd6, 16'h8000, 1'b1);
        step();
        idle();
        #1;
        chk("t4_hz1_queued", wb.hz_sr1, 1);
        chk("t4_hz2_queued", wb.hz_sr2, 0);
        wb.wb_hold = 1'b0;
        step();
        chk("t4_hz1_inflight", wb.hz_sr1, 1);
        step();
        chk("t4_hz1_cleared", wb.hz_sr1, 0);

        // Write without condition-code update
        set_alu(3'd2, 16'h7FFF, 1'b0);
        step();
        idle();
        step();
        chk("t6_wdata", {wb.reg_we, wb.reg_dr, wb.reg_wdata}, {1'b1, 3'd2, 16'h7FFF});
        chk("t6_cc", {wb.cc_n, wb.cc_z, wb.cc_p}, 3'b100);
        step();

        // Reset with entries queued and a write in flight
        set_alu(3'd1, 16'h0011, 1'b1);
        set_mem(3'd4, 16'h0022, 1'b1);
        repeat (4) step();
        chk("t5_pre_we", wb.reg_we, 1);
        chk("t5_pre_cnt", (wb.count >= 3), 1);
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        chk("t5_we", wb.reg_we, 0);
        chk("t5_count", wb.count, 0);
        chk("t5_cc", {wb.cc_n, wb.cc_z, wb.cc_p}, 3'b010);
        repeat (3) step();
        chk("t5_no_write", wb.reg_we, 0);

        // Random traffic; unaccepted requests are held unchanged
        for (int n = 0; n < 600; n++) begin
            if (!wb.alu_valid || alu_acc) begin
                wb.alu_valid  = ($urandom_range(0, 9) < 6);
                wb.alu_dr     = 3'($urandom);
                wb.alu_value  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                wb.alu_set_cc = 1'($urandom);
            end
            if (!wb.mem_valid || mem_acc) begin
                wb.mem_valid  = ($urandom_range(0, 9) < 5);
                wb.mem_dr     = 3'($urandom);
                wb.mem_value  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                wb.mem_set_cc = 1'($urandom);
            end
            wb.wb_hold = ($urandom_range(0, 3) == 0);
            wb.qry_sr1 = 3'($urandom);
            wb.qry_sr2 = 3'($urandom);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
